uart_tx_words: RTL and testbench



---
 rtl/uart_tx_words.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_words.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_words.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_words: FIFO-buffered UART transmitter for multi-byte words,      |
// | LSB byte first, optional parity, 1 or 2 stop bits, baud clock-enable.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_words #(
  parameter int CLOCK_FREQUENCY = 25_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int BYTES           = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                          clockIN,
  input  logic                          txResetIN,
  input  logic [8*BYTES-1:0]            txDataIN,
  input  logic                          txLoadIN,
  output logic                          txFullOUT,
  output logic [$clog2(FIFO_DEPTH):0]   txLevelOUT,
  output logic                          txIdleOUT,
  output logic                          txDoneOUT,
  output logic                          txOUT
);

  localparam int c_BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int c_CNT_W    = $clog2(c_BAUD_DIV);
  localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W    = c_PTR_W + 1;
  localparam int c_BYTE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [c_CNT_W-1:0]  c_BAUD_RELOAD = c_CNT_W'(c_BAUD_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_LVL_W-1:0]  c_FIFO_FULL   = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_LVL_W-1:0]  c_LVL_ONE     = c_LVL_W'(1);
  localparam logic [c_PTR_W-1:0]  c_PTR_ONE     = c_PTR_W'(1);
  localparam logic [c_BYTE_W-1:0] c_LAST_BYTE   = c_BYTE_W'(BYTES - 1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_ONE    = c_BYTE_W'(1);
  localparam logic                c_LAST_STOP   = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Word FIFO
  logic [8*BYTES-1:0] r_fifoMem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_LVL_W-1:0] r_level;

  // Transmit engine
  state_t             r_state;
  logic [c_CNT_W-1:0] r_baudCnt;
  logic [8*BYTES-1:0] r_shift;
  logic [c_BYTE_W-1:0] r_byteIdx;
  logic [2:0]         r_bitIdx;
  logic               r_stopIdx;
  logic               r_txOut;
  logic               r_done;

  logic               w_fifoValid;
  logic               w_push;
  logic               w_pop;
  logic               w_bitEnd;
  logic               w_lastStop;
  logic               w_lastByte;
  logic [7:0]         w_curByte;
  logic [2:0]         w_nextBit;
  logic               w_parityBit;
  logic [8*BYTES-1:0] w_fifoHead;

  assign w_fifoValid = (r_level != '0);
  assign w_push      = txLoadIN && (r_level != c_FIFO_FULL);
  assign w_bitEnd    = (r_baudCnt == '0);
  assign w_lastStop  = (r_stopIdx == c_LAST_STOP);
  assign w_lastByte  = (r_byteIdx == c_LAST_BYTE);
  assign w_curByte   = r_shift[7:0];
  assign w_nextBit   = r_bitIdx + 3'd1;
  assign w_parityBit = (PARITY == 1) ? ~^w_curByte : ^w_curByte;
  assign w_fifoHead  = r_fifoMem[r_rdPtr];

  // A pop happens from IDLE, or at the very end of a word so the next word starts without a gap
  assign w_pop = w_fifoValid &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_STOP) && w_bitEnd && w_lastStop && w_lastByte));

  always_ff @(posedge clockIN) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= txDataIN;
    end
  end

  always_ff @(posedge clockIN or posedge txResetIN) begin
    if (txResetIN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clockIN or posedge txResetIN) begin
    if (txResetIN) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= c_BAUD_RELOAD;
      r_shift   <= '0;
      r_byteIdx <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_txOut   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Held at reload in IDLE; reloaded on every bit boundary so START entry always sees a full bit
      if ((r_state != ST_IDLE) && !w_bitEnd) begin
        r_baudCnt <= r_baudCnt - c_CNT_ONE;
      end else begin
        r_baudCnt <= c_BAUD_RELOAD;
      end

      case (r_state)
        ST_IDLE: begin
          r_txOut <= 1'b1;
          if (w_fifoValid) begin
            r_shift   <= w_fifoHead;
            r_byteIdx <= '0;
            r_state   <= ST_START;
            r_txOut   <= 1'b0;
          end
        end

        ST_START: begin
          if (w_bitEnd) begin
            r_bitIdx <= 3'd0;
            r_state  <= ST_DATA;
            r_txOut  <= w_curByte[0];
          end
        end

        ST_DATA: begin
          if (w_bitEnd) begin
            if (r_bitIdx == 3'd7) begin
              if (PARITY != 0) begin
                r_state <= ST_PARITY;
                r_txOut <= w_parityBit;
              end else begin
                r_stopIdx <= 1'b0;
                r_state   <= ST_STOP;
                r_txOut   <= 1'b1;
              end
            end else begin
              r_bitIdx <= w_nextBit;
              r_txOut  <= w_curByte[w_nextBit];
            end
          end
        end

        ST_PARITY: begin
          if (w_bitEnd) begin
            r_stopIdx <= 1'b0;
            r_state   <= ST_STOP;
            r_txOut   <= 1'b1;
          end
        end

        ST_STOP: begin
          if (w_bitEnd) begin
            if (!w_lastStop) begin
              r_stopIdx <= r_stopIdx + 1'b1;
              r_txOut   <= 1'b1;
            end else if (!w_lastByte) begin
              r_byteIdx <= r_byteIdx + c_BYTE_ONE;
              r_shift   <= r_shift >> 8;
              r_state   <= ST_START;
              r_txOut   <= 1'b0;
            end else begin
              r_done <= 1'b1;
              if (w_fifoValid) begin
                r_shift   <= w_fifoHead;
                r_byteIdx <= '0;
                r_state   <= ST_START;
                r_txOut   <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_txOut <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_txOut <= 1'b1;
        end
      endcase
    end
  end

  assign txOUT      = r_txOut;
  assign txDoneOUT  = r_done;
  assign txLevelOUT = r_level;
  assign txFullOUT  = (r_level == c_FIFO_FULL);
  assign txIdleOUT  = (r_state == ST_IDLE) && !w_fifoValid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_words.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_words: scoreboard bench decoding the serial line of several   |
// | differently parameterised uart_tx_words instances.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_tx_words;

  logic clockIN = 1'b0;
  logic txResetIN;

  // A: 4 bytes, no parity, 1 stop   B: 1 byte even   C: 1 byte odd
  // D: 2 bytes, no parity, 1 stop   E: 2 bytes, no parity, 2 stop
  logic [31:0] dataA;  logic loadA, fullA, idleA, doneA, lineA;  logic [2:0] levelA;
  logic [7:0]  dataB;  logic loadB, fullB, idleB, doneB, lineB;  logic [2:0] levelB;
  logic [7:0]  dataC;  logic loadC, fullC, idleC, doneC, lineC;  logic [2:0] levelC;
  logic [15:0] dataD;  logic loadD, fullD, idleD, doneD, lineD;  logic [2:0] levelD;
  logic [15:0] dataE;  logic loadE, fullE, idleE, doneE, lineE;  logic [2:0] levelE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int doneCntD = 0;
  logic [63:0] sbq [$];

  uart_tx_words #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .BYTES(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) uA (
    .clockIN(clockIN), .txResetIN(txResetIN), .txDataIN(dataA), .txLoadIN(loadA), .txFullOUT(fullA),
    .txLevelOUT(levelA), .txIdleOUT(idleA), .txDoneOUT(doneA), .txOUT(lineA));
  uart_tx_words #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .BYTES(1), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) uB (
    .clockIN(clockIN), .txResetIN(txResetIN), .txDataIN(dataB), .txLoadIN(loadB), .txFullOUT(fullB),
    .txLevelOUT(levelB), .txIdleOUT(idleB), .txDoneOUT(doneB), .txOUT(lineB));
  uart_tx_words #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .BYTES(1), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) uC (
    .clockIN(clockIN), .txResetIN(txResetIN), .txDataIN(dataC), .txLoadIN(loadC), .txFullOUT(fullC),
    .txLevelOUT(levelC), .txIdleOUT(idleC), .txDoneOUT(doneC), .txOUT(lineC));
  uart_tx_words #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .BYTES(2), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) uD (
    .clockIN(clockIN), .txResetIN(txResetIN), .txDataIN(dataD), .txLoadIN(loadD), .txFullOUT(fullD),
    .txLevelOUT(levelD), .txIdleOUT(idleD), .txDoneOUT(doneD), .txOUT(lineD));
  uart_tx_words #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .BYTES(2), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) uE (
    .clockIN(clockIN), .txResetIN(txResetIN), .txDataIN(dataE), .txLoadIN(loadE), .txFullOUT(fullE),
    .txLevelOUT(levelE), .txIdleOUT(idleE), .txDoneOUT(doneE), .txOUT(lineE));

  initial forever #5 clockIN = ~clockIN;

  always @(posedge clockIN) begin
    cyc <= cyc + 1;
    if (doneD) doneCntD <= doneCntD + 1;
  end

  function automatic logic lineOf(input int sel);
    case (sel)
      0: return lineA;  1: return lineB;  2: return lineC;  3: return lineD;
      default: return lineE;
    endcase
  endfunction

  function automatic logic doneOf(input int sel);
    case (sel)
      0: return doneA;  1: return doneB;  2: return doneC;  3: return doneD;
      default: return doneE;
    endcase
  endfunction

  function automatic logic idleOf(input int sel);
    case (sel)
      0: return idleA;  1: return idleB;  2: return idleC;  3: return idleD;
      default: return idleE;
    endcase
  endfunction

  function automatic logic fullOf(input int sel);
    case (sel)
      0: return fullA;  1: return fullB;  2: return fullC;  3: return fullD;
      default: return fullE;
    endcase
  endfunction

  function automatic logic [2:0] levelOf(input int sel);
    case (sel)
      0: return levelA;  1: return levelB;  2: return levelC;  3: return levelD;
      default: return levelE;
    endcase
  endfunction

  task automatic setLoad(input int sel, input logic [63:0] w, input logic en);
    case (sel)
      0: begin dataA = w[31:0]; loadA = en; end
      1: begin dataB = w[7:0];  loadB = en; end
      2: begin dataC = w[7:0];  loadC = en; end
      3: begin dataD = w[15:0]; loadD = en; end
      default: begin dataE = w[15:0]; loadE = en; end
    endcase
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clockIN);
  endtask

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decode one word from the line of instance sel, sampling mid-bit, then score it.
  task automatic rxWord(input int sel, input int nBytes, input int par, input int stops, output int tFall);
    int waited;
    logic [63:0] got;
    logic [63:0] exp;
    logic [7:0] b;
    logic [7:0] eb;
    logic [7:0] pbits;
    logic [7:0] expP;
    waited = 0;
    got = '0;
    pbits = '0;
    expP = '0;
    b = '0;
    tFall = cyc;
    while (lineOf(sel) !== 1'b0 && waited < 400) begin
      waitNeg(1);
      waited++;
    end
    checkValue("start_seen", 64'(lineOf(sel)), 64'd0);
    if (lineOf(sel) !== 1'b0) return;
    tFall = cyc;
    for (int k = 0; k < nBytes; k++) begin
      waitNeg(7);
      checkValue("start_bit", 64'(lineOf(sel)), 64'd0);
      for (int i = 0; i < 8; i++) begin
        waitNeg(16);
        b[i] = lineOf(sel);
      end
      got[8*k +: 8] = b;
      if (par != 0) begin
        waitNeg(16);
        pbits[k] = lineOf(sel);
      end
      for (int s = 0; s < stops; s++) begin
        waitNeg(16);
        checkValue("stop_bit", 64'(lineOf(sel)), 64'd1);
      end
      waitNeg(8);
      checkValue("stop_end", 64'(lineOf(sel)), 64'd1);
      if (k == nBytes - 1) checkValue("done_early", 64'(doneOf(sel)), 64'd0);
      waitNeg(1);
      if (k < nBytes - 1) checkValue("next_start", 64'(lineOf(sel)), 64'd0);
      else                checkValue("done_pulse", 64'(doneOf(sel)), 64'd1);
    end
    checkValue("sb_pending", 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      exp = sbq.pop_front();
      checkValue("word_data", got, exp);
      if (par != 0) begin
        for (int k = 0; k < nBytes; k++) begin
          eb = exp[8*k +: 8];
          expP[k] = (par == 1) ? ~^eb : ^eb;
        end
        checkValue("parity_bits", 64'(pbits), 64'(expP));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tw [5];
    int dc0;
    int lowCnt;
    logic [63:0] streamWords [6];
    streamWords[0] = 64'h1234; streamWords[1] = 64'hBEEF; streamWords[2] = 64'h0001;
    streamWords[3] = 64'h8000; streamWords[4] = 64'h5A5A; streamWords[5] = 64'hFFFF;

    txResetIN = 1'b1;
    for (int s = 0; s < 5; s++) setLoad(s, 64'd0, 1'b0);
    waitNeg(2);
    checkValue("rst_line_A", 64'(lineA), 64'd1);
    checkValue("rst_idle_A", 64'(idleA), 64'd1);
    checkValue("rst_level_A", 64'(levelA), 64'd0);
    checkValue("rst_full_A", 64'(fullA), 64'd0);
    checkValue("rst_done_A", 64'(doneA), 64'd0);
    checkValue("rst_line_E", 64'(lineE), 64'd1);
    txResetIN = 1'b0;
    waitNeg(2);

    // 4-byte word: latency, byte order, 640-clock duration
    setLoad(0, 64'hA5C3_0F81, 1'b1);
    sbq.push_back(64'hA5C3_0F81);
    waitNeg(1);
    setLoad(0, 64'hA5C3_0F81, 1'b0);
    checkValue("A_line_push_edge", 64'(lineA), 64'd1);
    checkValue("A_idle_after_push", 64'(idleA), 64'd0);
    checkValue("A_level_after_push", 64'(levelA), 64'd1);
    waitNeg(1);
    checkValue("A_line_fall", 64'(lineA), 64'd0);
    checkValue("A_level_after_pop", 64'(levelA), 64'd0);
    t0 = cyc;
    rxWord(0, 4, 0, 1, tw[0]);
    checkValue("A_word_clocks", 64'(cyc - t0), 64'd640);
    checkValue("A_idle_end", 64'(idleA), 64'd1);
    waitNeg(1);
    checkValue("A_done_one_cycle", 64'(doneA), 64'd0);

    // single byte, even and odd parity
    setLoad(1, 64'h07, 1'b1);
    sbq.push_back(64'h07);
    waitNeg(1);
    setLoad(1, 64'h07, 1'b0);
    waitNeg(1);
    t0 = cyc;
    rxWord(1, 1, 2, 1, tw[0]);
    checkValue("B_frame_clocks", 64'(cyc - t0), 64'd176);
    waitNeg(3);

    setLoad(2, 64'h07, 1'b1);
    sbq.push_back(64'h07);
    waitNeg(1);
    setLoad(2, 64'h07, 1'b0);
    rxWord(2, 1, 1, 1, tw[0]);
    waitNeg(3);

    // two stop bits: rxWord checks the next start edge lands exactly after both stops
    setLoad(4, 64'h00FF, 1'b1);
    sbq.push_back(64'h00FF);
    waitNeg(1);
    setLoad(4, 64'h00FF, 1'b0);
    rxWord(4, 2, 0, 2, tw[0]);
    checkValue("E_idle_end", 64'(idleE), 64'd1);
    waitNeg(3);

    // six back-to-back pushes into a depth-4 FIFO
    dc0 = doneCntD;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 1) checkValue("D_idle_after_push", 64'(idleD), 64'd0);
          if (i == 5) begin
            checkValue("D_full_at_6th", 64'(fullD), 64'd1);
            checkValue("D_level_at_6th", 64'(levelD), 64'd4);
          end
          setLoad(3, streamWords[i], 1'b1);
          if (i < 5) sbq.push_back(streamWords[i]);
          waitNeg(1);
        end
        setLoad(3, 64'd0, 1'b0);
        checkValue("D_level_after_drop", 64'(levelD), 64'd4);
      end
      begin
        for (int w = 0; w < 5; w++) rxWord(3, 2, 0, 1, tw[w]);
      end
    join
    for (int w = 1; w < 5; w++) checkValue("D_word_spacing", 64'(tw[w] - tw[w-1]), 64'd320);
    checkValue("D_stream_clocks", 64'(cyc - tw[0]), 64'd1600);
    checkValue("D_idle_end", 64'(idleD), 64'd1);
    waitNeg(1);
    checkValue("D_done_count", 64'(doneCntD - dc0), 64'd5);
    checkValue("D_sb_drained", 64'(sbq.size()), 64'd0);
    waitNeg(3);

    // asynchronous reset mid-word with two words queued
    for (int i = 0; i < 3; i++) begin
      setLoad(3, streamWords[i], 1'b1);
      waitNeg(1);
    end
    setLoad(3, 64'd0, 1'b0);
    waitNeg(97);
    checkValue("R_level_before", 64'(levelD), 64'd2);
    #2;
    txResetIN = 1'b1;
    #1;
    checkValue("R_line_async", 64'(lineD), 64'd1);
    checkValue("R_level_async", 64'(levelD), 64'd0);
    checkValue("R_idle_async", 64'(idleD), 64'd1);
    checkValue("R_full_async", 64'(fullD), 64'd0);
    checkValue("R_done_async", 64'(doneD), 64'd0);
    @(negedge clockIN);
    txResetIN = 1'b0;
    lowCnt = 0;
    for (int i = 0; i < 300; i++) begin
      waitNeg(1);
      if (lineD !== 1'b1 || idleD !== 1'b1) lowCnt++;
    end
    checkValue("R_quiet_after_release", 64'(lowCnt), 64'd0);
    setLoad(3, 64'hC0DE, 1'b1);
    sbq.push_back(64'hC0DE);
    waitNeg(1);
    setLoad(3, 64'd0, 1'b0);
    rxWord(3, 2, 0, 1, tw[0]);
    checkValue("R_idle_final", 64'(idleD), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
